// File: rtl/apu_frame_seq.sv
// apu_frame_seq: APU frame sequencer. Counts CPU cycles and emits quarter/half-frame strobes
// in 4-step or 5-step mode, raises the frame IRQ in 4-step mode, and applies the delayed
// counter reset that follows a write to $4017.
module apu_frame_seq #(
    parameter int unsigned P_STEP1 = 7457,
    parameter int unsigned P_STEP2 = 14913,
    parameter int unsigned P_STEP3 = 22371,
    parameter int unsigned P_STEP4 = 29829,
    parameter int unsigned P_STEP5 = 37281
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       cpu_clock,
    input  logic       apu_cs,
    input  logic [4:0] ioreg_addr,
    input  logic [7:0] ioreg_datain,
    input  logic       ioreg_wr,
    input  logic       ioreg_rd,
    output logic       frame_e,
    output logic       frame_l,
    output logic       frame_irq,
    output logic       seq_mode
);

    localparam logic [15:0] Step1 = 16'(P_STEP1);
    localparam logic [15:0] Step2 = 16'(P_STEP2);
    localparam logic [15:0] Step3 = 16'(P_STEP3);
    localparam logic [15:0] Step4 = 16'(P_STEP4);
    localparam logic [15:0] Step5 = 16'(P_STEP5);
    localparam logic [15:0] IrqLo = 16'(P_STEP4 - 1);
    localparam logic [15:0] Wrap4 = 16'(P_STEP4 + 1);
    localparam logic [15:0] Wrap5 = 16'(P_STEP5 + 1);

    logic [15:0] cyc_q, cyc_d;
    logic        parity_q, parity_d;
    logic        mode_q, mode_d;
    logic        inhibit_q, inhibit_d;
    logic        irq_q, irq_d;
    logic [2:0]  dly_q, dly_d;
    logic        pending_q, pending_d;
    logic        e_q, e_d;
    logic        l_q, l_d;

    logic wr17, rd15, eff_mode, eff_inhibit, dly_fire, wrap, irq_set;

    // Only bits 7:6 of the $4017 data matter to this block.
    logic unused_data;
    assign unused_data = ^ioreg_datain[5:0];

    // Decode register accesses; a $4017 write steers mode/inhibit on the very tick it lands.
    always_comb begin
        wr17        = cpu_clock & apu_cs & (ioreg_addr == 5'h17) & ioreg_wr;
        rd15        = cpu_clock & apu_cs & (ioreg_addr == 5'h15) & ioreg_rd;
        eff_mode    = wr17 ? ioreg_datain[7] : mode_q;
        eff_inhibit = wr17 ? ioreg_datain[6] : inhibit_q;
        // A fresh write restarts the delay, so it pre-empts an expiring one.
        dly_fire    = cpu_clock & pending_q & (dly_q == 3'd1) & ~wr17;
        wrap        = eff_mode ? (cyc_q == Wrap5) : (cyc_q == Wrap4);
        irq_set     = cpu_clock & ~eff_mode & ~eff_inhibit & (cyc_q >= IrqLo) & (cyc_q <= Wrap4);
    end

    // Next-state for counter, flags, delayed reset and step strobes.
    always_comb begin
        cyc_d     = cyc_q;
        parity_d  = parity_q;
        mode_d    = mode_q;
        inhibit_d = inhibit_q;
        irq_d     = irq_q;
        dly_d     = dly_q;
        pending_d = pending_q;
        e_d       = 1'b0;
        l_d       = 1'b0;
        if (cpu_clock) begin
            parity_d  = ~parity_q;
            mode_d    = eff_mode;
            inhibit_d = eff_inhibit;

            if (dly_fire || wrap) begin
                cyc_d = '0;
            end else begin
                cyc_d = cyc_q + 16'd1;
            end

            if (dly_fire) begin
                // Delayed reset clocks the envelopes/length counters only in 5-step mode.
                e_d = eff_mode;
                l_d = eff_mode;
            end else begin
                if (cyc_q == Step1 || cyc_q == Step3) begin
                    e_d = 1'b1;
                end
                if (cyc_q == Step2) begin
                    e_d = 1'b1;
                    l_d = 1'b1;
                end
                if (cyc_q == Step4 && !eff_mode) begin
                    e_d = 1'b1;
                    l_d = 1'b1;
                end
                if (cyc_q == Step5 && eff_mode) begin
                    e_d = 1'b1;
                    l_d = 1'b1;
                end
            end

            // Set beats a coincident clear.
            if (irq_set) begin
                irq_d = 1'b1;
            end else if (rd15 || (wr17 && ioreg_datain[6])) begin
                irq_d = 1'b0;
            end

            if (wr17) begin
                dly_d     = parity_q ? 3'd3 : 3'd4;
                pending_d = 1'b1;
            end else if (pending_q) begin
                dly_d = dly_q - 3'd1;
                if (dly_q == 3'd1) begin
                    pending_d = 1'b0;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            cyc_q     <= '0;
            parity_q  <= 1'b0;
            mode_q    <= 1'b0;
            inhibit_q <= 1'b0;
            irq_q     <= 1'b0;
            dly_q     <= '0;
            pending_q <= 1'b0;
            e_q       <= 1'b0;
            l_q       <= 1'b0;
        end else begin
            cyc_q     <= cyc_d;
            parity_q  <= parity_d;
            mode_q    <= mode_d;
            inhibit_q <= inhibit_d;
            irq_q     <= irq_d;
            dly_q     <= dly_d;
            pending_q <= pending_d;
            e_q       <= e_d;
            l_q       <= l_d;
        end
    end

    assign frame_e   = e_q;
    assign frame_l   = l_q;
    assign frame_irq = irq_q;
    assign seq_mode  = mode_q;

endmodule
